imem_port_arbiter: RTL and testbench

Shares one single-port instruction/data memory among three requesters from the RISC-V core: instruction fetch, data read and data write. It replaces the dual-port access pattern so the boot/program RAM maps onto single-port block RAM. It sits between the core's memory ports and the RAM in the board top level. Arbitration uses fixed priority with a starvation guard for fetch.

---
 rtl/imem_arb_pkg.sv | 13 +
 rtl/imem_spram.sv | 29 ++
 rtl/imem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_imem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package imem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_DREAD
   } owner_t;

   localparam int             STALL_W   = 16;
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/imem_spram.sv
// Byte-enabled single-port RAM, one-cycle read latency.
module imem_spram #(
   parameter int    ADDR_WIDTH = 9,
   parameter int    DATA_WIDTH = 32,
   parameter string INIT_FILE  = ""
) (
   input  logic                    clock,
   input  logic                    i_en,
   input  logic [DATA_WIDTH/8-1:0] i_we,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int BW = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   // A write cycle does not refresh the read port, so a zero-strobe write behaves as a read.
   always_ff @(posedge clock) begin
      if (i_en) begin
         for (int b = 0; b < BW; b++) begin
            if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
         end
         if (i_we == '0) o_rdata <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-port RAM between fetch, data read and data write with fixed
// priority (write > read > fetch) and a starvation override for fetch.
//
// owner      | meaning
// OWN_NONE   | no read was granted last cycle; no response this cycle
// OWN_FETCH  | fetch was granted last cycle; RAM data goes to fetch port
// OWN_DREAD  | data read was granted last cycle; RAM data goes to dread port
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 9,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    fetch_req,
   input  logic [ADDR_WIDTH-1:0]   fetch_addr,
   output logic                    fetch_gnt,
   output logic                    fetch_rvalid,
   output logic [DATA_WIDTH-1:0]   fetch_rdata,
   input  logic                    dread_req,
   input  logic [ADDR_WIDTH+1:0]   dread_addr,
   output logic                    dread_gnt,
   output logic                    dread_rvalid,
   output logic [DATA_WIDTH-1:0]   dread_rdata,
   input  logic                    dwrite_req,
   input  logic [ADDR_WIDTH+1:0]   dwrite_addr,
   input  logic [DATA_WIDTH-1:0]   dwrite_data,
   input  logic [DATA_WIDTH/8-1:0] dwrite_strb,
   output logic                    dwrite_gnt,
   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic [STALL_W-1:0]      stall_count
);

   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0]      r_starve_cnt;
   logic [SW-1:0]      w_starve_nxt;
   owner_t             r_owner;
   owner_t             w_owner_nxt;
   logic [STALL_W-1:0] r_stall_count;
   logic [STALL_W-1:0] w_stall_nxt;
   logic               w_force;
   logic               w_fetch_gnt;
   logic               w_dread_gnt;
   logic               w_dwrite_gnt;
   logic               w_denied;
   logic               w_unused;

   assign w_unused = ^{dread_addr[1:0], dwrite_addr[1:0]};

   // Grants are masked during reset so nothing reaches the RAM in a reset cycle.
   assign w_force      = fetch_req && (r_starve_cnt == STARVE_MAX);
   assign w_dwrite_gnt = resetn && dwrite_req && !w_force;
   assign w_dread_gnt  = resetn && dread_req && !dwrite_req && !w_force;
   assign w_fetch_gnt  = resetn && fetch_req && (w_force || (!dwrite_req && !dread_req));

   assign w_denied = (fetch_req  && !w_fetch_gnt)
                  || (dread_req  && !w_dread_gnt)
                  || (dwrite_req && !w_dwrite_gnt);

   always_comb begin
      w_starve_nxt = '0;
      w_owner_nxt  = OWN_NONE;
      w_stall_nxt  = r_stall_count;
      if (fetch_req && !w_fetch_gnt) begin
         w_starve_nxt = (r_starve_cnt == STARVE_MAX) ? r_starve_cnt : r_starve_cnt + 1'b1;
      end
      if (w_fetch_gnt) begin
         w_owner_nxt = OWN_FETCH;
      end else if (w_dread_gnt) begin
         w_owner_nxt = OWN_DREAD;
      end
      if (w_denied && (r_stall_count != STALL_MAX)) begin
         w_stall_nxt = r_stall_count + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_starve_cnt  <= '0;
         r_owner       <= OWN_NONE;
         r_stall_count <= '0;
      end else begin
         r_starve_cnt  <= w_starve_nxt;
         r_owner       <= w_owner_nxt;
         r_stall_count <= w_stall_nxt;
      end
   end

   always_comb begin
      mem_en    = w_fetch_gnt || w_dread_gnt || w_dwrite_gnt;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_dwrite_gnt) begin
         mem_we    = dwrite_strb;
         mem_addr  = dwrite_addr[ADDR_WIDTH+1:2];
         mem_wdata = dwrite_data;
      end else if (w_dread_gnt) begin
         mem_addr = dread_addr[ADDR_WIDTH+1:2];
      end else if (w_fetch_gnt) begin
         mem_addr = fetch_addr;
      end
   end

   assign fetch_gnt    = w_fetch_gnt;
   assign dread_gnt    = w_dread_gnt;
   assign dwrite_gnt   = w_dwrite_gnt;
   assign fetch_rvalid = resetn && (r_owner == OWN_FETCH);
   assign dread_rvalid = resetn && (r_owner == OWN_DREAD);
   assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
   assign dread_rdata  = dread_rvalid ? mem_rdata : '0;
   assign stall_count  = resetn ? r_stall_count : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter with the shared RAM; every cycle is compared against a behavioural model.
module tb_imem_port_arbiter;

   localparam int AW  = 9;
   localparam int DW  = 32;
   localparam int BW  = DW / 8;
   localparam int LIM = 4;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          fetch_req = 1'b0;
   logic [AW-1:0] fetch_addr = '0;
   logic          fetch_gnt, fetch_rvalid;
   logic [DW-1:0] fetch_rdata;
   logic          dread_req = 1'b0;
   logic [AW+1:0] dread_addr = '0;
   logic          dread_gnt, dread_rvalid;
   logic [DW-1:0] dread_rdata;
   logic          dwrite_req = 1'b0;
   logic [AW+1:0] dwrite_addr = '0;
   logic [DW-1:0] dwrite_data = '0;
   logic [BW-1:0] dwrite_strb = '0;
   logic          dwrite_gnt;
   logic          mem_en;
   logic [BW-1:0] mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [15:0]   stall_count;

   always #5 clock = ~clock;

   imem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
      .clock(clock), .resetn(resetn),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .dread_req(dread_req), .dread_addr(dread_addr), .dread_gnt(dread_gnt),
      .dread_rvalid(dread_rvalid), .dread_rdata(dread_rdata),
      .dwrite_req(dwrite_req), .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data),
      .dwrite_strb(dwrite_strb), .dwrite_gnt(dwrite_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_count(stall_count)
   );

   imem_spram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_FILE("")) u_ram (
      .clock(clock), .i_en(mem_en), .i_we(mem_we), .i_addr(mem_addr),
      .i_wdata(mem_wdata), .o_rdata(mem_rdata)
   );

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who wins, how long fetch has waited, pending read reply, stall total, RAM image.
   localparam int P_NONE = 0, P_FETCH = 1, P_DREAD = 2, P_DWRITE = 3;
   int            m_win;
   int            m_wait;
   int            m_stall;
   bit            m_pv_f, m_pv_d;
   logic [DW-1:0] m_pdata;
   logic [DW-1:0] m_mem [64];

   task automatic eval();
      logic [AW-1:0] ea;
      #1;
      if (!resetn)                        m_win = P_NONE;
      else if (fetch_req && m_wait == LIM) m_win = P_FETCH;
      else if (dwrite_req)                m_win = P_DWRITE;
      else if (dread_req)                 m_win = P_DREAD;
      else if (fetch_req)                 m_win = P_FETCH;
      else                                m_win = P_NONE;
      case (m_win)
         P_FETCH:  ea = fetch_addr;
         P_DREAD:  ea = dread_addr[AW+1:2];
         P_DWRITE: ea = dwrite_addr[AW+1:2];
         default:  ea = '0;
      endcase
      chk("fetch_gnt",    64'(fetch_gnt),    64'(m_win == P_FETCH));
      chk("dread_gnt",    64'(dread_gnt),    64'(m_win == P_DREAD));
      chk("dwrite_gnt",   64'(dwrite_gnt),   64'(m_win == P_DWRITE));
      chk("mem_en",       64'(mem_en),       64'(m_win != P_NONE));
      chk("mem_we",       64'(mem_we),       (m_win == P_DWRITE) ? 64'(dwrite_strb) : 64'd0);
      chk("mem_addr",     64'(mem_addr),     64'(ea));
      chk("mem_wdata",    64'(mem_wdata),    (m_win == P_DWRITE) ? 64'(dwrite_data) : 64'd0);
      chk("fetch_rvalid", 64'(fetch_rvalid), 64'(resetn && m_pv_f));
      chk("fetch_rdata",  64'(fetch_rdata),  (resetn && m_pv_f) ? 64'(m_pdata) : 64'd0);
      chk("dread_rvalid", 64'(dread_rvalid), 64'(resetn && m_pv_d));
      chk("dread_rdata",  64'(dread_rdata),  (resetn && m_pv_d) ? 64'(m_pdata) : 64'd0);
      chk("stall_count",  64'(stall_count),  resetn ? 64'(m_stall) : 64'd0);
   endtask

   task automatic adv();
      bit denied;
      if (!resetn) begin
         m_wait = 0; m_stall = 0; m_pv_f = 0; m_pv_d = 0;
      end else begin
         denied = (fetch_req && m_win != P_FETCH) || (dread_req && m_win != P_DREAD)
               || (dwrite_req && m_win != P_DWRITE);
         if (denied && m_stall < 65535) m_stall++;
         if (fetch_req && m_win != P_FETCH) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
         else                               m_wait = 0;
         m_pv_f = (m_win == P_FETCH);
         m_pv_d = (m_win == P_DREAD);
         if (m_win == P_FETCH) m_pdata = m_mem[fetch_addr[5:0]];
         if (m_win == P_DREAD) m_pdata = m_mem[dread_addr[7:2]];
         if (m_win == P_DWRITE)
            for (int b = 0; b < BW; b++)
               if (dwrite_strb[b]) m_mem[dwrite_addr[7:2]][b*8 +: 8] = dwrite_data[b*8 +: 8];
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic cyc();
      eval();
      adv();
   endtask

   task automatic idle();
      fetch_req = 0; dread_req = 0; dwrite_req = 0;
   endtask

   task automatic do_reset();
      idle();
      resetn = 0;
      cyc();
      resetn = 1;
   endtask

   function automatic logic [AW+1:0] baddr(input int word);
      return {AW'(word), 2'($urandom_range(0, 3))};
   endfunction

   typedef struct {
      bit            f, r, w;
      logic [BW-1:0] strb;
      bit            ef, er, ew;
      logic [BW-1:0] ewe;
   } vec_t;

   vec_t tbl [9];
   int   fgnt;

   initial begin
      tbl[0] = '{0, 0, 0, 4'h0, 0, 0, 0, 4'h0};
      tbl[1] = '{1, 0, 0, 4'h0, 1, 0, 0, 4'h0};
      tbl[2] = '{0, 1, 0, 4'h0, 0, 1, 0, 4'h0};
      tbl[3] = '{0, 0, 1, 4'hF, 0, 0, 1, 4'hF};
      tbl[4] = '{0, 0, 1, 4'h0, 0, 0, 1, 4'h0};
      tbl[5] = '{1, 1, 0, 4'h0, 0, 1, 0, 4'h0};
      tbl[6] = '{1, 0, 1, 4'h5, 0, 0, 1, 4'h5};
      tbl[7] = '{0, 1, 1, 4'h3, 0, 0, 1, 4'h3};
      tbl[8] = '{1, 1, 1, 4'hC, 0, 0, 1, 4'hC};

      m_wait = 0; m_stall = 0; m_pv_f = 0; m_pv_d = 0; m_pdata = '0; m_win = P_NONE;
      @(negedge clock);
      do_reset();
      do_reset();

      // Preload words 0..63 with 0x1000+i through the write port.
      for (int i = 0; i < 64; i++) begin
         dwrite_req = 1; dwrite_addr = baddr(i); dwrite_data = 32'h1000 + i; dwrite_strb = 4'hF;
         cyc();
      end
      idle();

      // Fetch-only streaming.
      for (int i = 0; i < 9; i++) begin
         fetch_req = (i < 8); fetch_addr = AW'(i);
         eval();
         if (i < 8) chk("fo_gnt", 64'(fetch_gnt), 64'd1);
         if (i > 0) begin
            chk("fo_rvalid", 64'(fetch_rvalid), 64'd1);
            chk("fo_rdata", 64'(fetch_rdata), 64'(32'h1000 + i - 1));
         end
         chk("fo_stall", 64'(stall_count), 64'd0);
         adv();
      end
      idle();

      // Single-cycle priority table; an idle cycle follows to clear the fetch wait and see the reply.
      foreach (tbl[k]) begin
         fetch_req = tbl[k].f; fetch_addr = AW'($urandom_range(0, 63));
         dread_req = tbl[k].r; dread_addr = baddr($urandom_range(0, 63));
         dwrite_req = tbl[k].w; dwrite_addr = baddr($urandom_range(0, 63));
         dwrite_data = $urandom; dwrite_strb = tbl[k].strb;
         eval();
         chk("tbl_fgnt", 64'(fetch_gnt), 64'(tbl[k].ef));
         chk("tbl_rgnt", 64'(dread_gnt), 64'(tbl[k].er));
         chk("tbl_wgnt", 64'(dwrite_gnt), 64'(tbl[k].ew));
         chk("tbl_en", 64'(mem_en), 64'(tbl[k].ef || tbl[k].er || tbl[k].ew));
         chk("tbl_we", 64'(mem_we), 64'(tbl[k].ewe));
         adv();
         idle();
         eval();
         chk("tbl_frv", 64'(fetch_rvalid), 64'(tbl[k].ef));
         chk("tbl_rrv", 64'(dread_rvalid), 64'(tbl[k].er));
         adv();
      end

      // Write and read of the same word in the same cycle.
      do_reset();
      dwrite_req = 1; dwrite_addr = 11'h010; dwrite_data = 32'hDEADBEEF; dwrite_strb = 4'hF;
      dread_req = 1; dread_addr = 11'h010;
      eval();
      chk("col_wgnt", 64'(dwrite_gnt), 64'd1);
      chk("col_rgnt0", 64'(dread_gnt), 64'd0);
      adv();
      dwrite_req = 0;
      eval();
      chk("col_rgnt1", 64'(dread_gnt), 64'd1);
      adv();
      dread_req = 0;
      eval();
      chk("col_rdata", 64'(dread_rdata), 64'hDEADBEEF);
      chk("col_stall", 64'(stall_count), 64'd1);
      adv();

      // Continuous data reads with fetch held: fetch wins every fifth cycle.
      do_reset();
      fetch_req = 1; fetch_addr = AW'(3);
      dread_req = 1; dread_addr = baddr(7);
      for (int k = 0; k < 15; k++) begin
         eval();
         chk("stv_fgnt", 64'(fetch_gnt), 64'((k % 5) == 4));
         chk("stv_rgnt", 64'(dread_gnt), 64'((k % 5) != 4));
         adv();
         if (m_win == P_FETCH) fetch_addr = AW'($urandom_range(0, 63));
         if (m_win == P_DREAD) dread_addr = baddr($urandom_range(0, 63));
      end
      idle();

      // Partial-strobe merge.
      do_reset();
      dwrite_req = 1; dwrite_addr = baddr(32); dwrite_data = 32'h11223344; dwrite_strb = 4'hF;
      cyc();
      dwrite_data = 32'hAAAA5555; dwrite_strb = 4'h3;
      cyc();
      dwrite_req = 0; dread_req = 1; dread_addr = baddr(32);
      cyc();
      dread_req = 0;
      eval();
      chk("strb_rdata", 64'(dread_rdata), 64'h11225555);
      adv();

      // Reset in the cycle after a data read grant drops the reply.
      dread_req = 1; dread_addr = baddr(5);
      cyc();
      dread_req = 0; fetch_req = 1; resetn = 0;
      eval();
      chk("rst_rrv", 64'(dread_rvalid), 64'd0);
      chk("rst_fgnt", 64'(fetch_gnt), 64'd0);
      chk("rst_en", 64'(mem_en), 64'd0);
      adv();
      resetn = 1; fetch_req = 0;
      eval();
      chk("rst_rrv2", 64'(dread_rvalid), 64'd0);
      chk("rst_frv2", 64'(fetch_rvalid), 64'd0);
      chk("rst_stall", 64'(stall_count), 64'd0);
      adv();

      // Randomised traffic with hold-until-granted requesters.
      for (int k = 0; k < 400; k++) begin
         cyc();
         if (!fetch_req || m_win == P_FETCH) begin
            fetch_req = 1'($urandom_range(0, 1)); fetch_addr = AW'($urandom_range(0, 63));
         end
         if (!dread_req || m_win == P_DREAD) begin
            dread_req = 1'($urandom_range(0, 1)); dread_addr = baddr($urandom_range(0, 63));
         end
         if (!dwrite_req || m_win == P_DWRITE) begin
            dwrite_req = ($urandom_range(0, 2) == 0); dwrite_addr = baddr($urandom_range(0, 63));
            dwrite_data = $urandom; dwrite_strb = 4'($urandom);
         end
      end
      idle();
      cyc();

      // Long write pressure with fetch held: stall counter saturates, fetch still served.
      do_reset();
      fgnt = 0;
      fetch_req = 1; fetch_addr = AW'(1);
      dwrite_req = 1; dwrite_addr = baddr(63); dwrite_data = 32'h5A5A0000; dwrite_strb = 4'hF;
      for (int k = 0; k < 70000; k++) begin
         eval();
         if (fetch_gnt) fgnt++;
         adv();
         dwrite_data = $urandom; dwrite_strb = 4'($urandom);
      end
      chk("sat_stall", 64'(stall_count), 64'hFFFF);
      chk("sat_fgnt_count", 64'(fgnt), 64'd14000);
      idle();
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
